tdc_spi_slave: RTL and testbench

- SPI mode-0 responder (CPOL=0, CPHA=0), MSB first, 8-bit words, multiple bytes per CS frame.
- Used as an on-FPGA TDC register-file emulator, and as a loopback target for the TDC SPI master during bring-up.
- Oversamples the asynchronous sck/cs/mosi pins in the system clock domain.
- Exposes byte-level handshakes: a received-byte strobe, and a one-deep transmit holding register.

---
 rtl/tdc_spi_pkg.sv | 15 +
 rtl/spi_pin_sync.sv | 25 ++
 rtl/tdc_spi_slave.sv | 156 +++++++++++++++
 tb/tb_tdc_spi_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_spi_pkg.sv
// Shared definitions for the TDC SPI responder and the master-side verification.
package tdc_spi_pkg;

  localparam int unsigned SPI_WORD_W = 8;
  localparam int unsigned SPI_CNT_W  = 3;
  localparam bit          SPI_CPOL   = 1'b0;
  localparam bit          SPI_CPHA   = 1'b0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACTIVE       = 2'd1,
    WAIT_CS_HIGH = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin with edge detection.
module spi_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic pin,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // No reset: the chain keeps tracking the pin so the level is valid at reset release.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], pin};
    prev_q <= sync_q[STAGES-1];
  end

  assign level  = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/tdc_spi_slave.sv
// SPI mode-0 responder, MSB first, oversampled in the clk domain, with a
// one-deep transmit holding register and byte-level receive strobe.
module tdc_spi_slave
  import tdc_spi_pkg::*;
#(
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [SPI_WORD_W-1:0] IDLE_TX     = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_active,
  output logic                  frame_end,
  output logic                  rx_abort,
  output logic                  tx_underrun
);

  logic sck_level_unused, sck_rise_c, sck_fall_c;
  logic cs_level, cs_rise_c, cs_fall_c;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .pin(sck), .level(sck_level_unused), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .pin(cs), .level(cs_level), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .pin(mosi), .level(mosi_level), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  spi_state_e            state;
  logic [SPI_CNT_W-1:0]  bit_cnt;
  logic [SPI_WORD_W-1:0] rx_shift;
  logic [SPI_WORD_W-1:0] tx_shift;
  logic [SPI_WORD_W-1:0] hold;
  logic                  rx_pend;

  logic                  reload_c;
  logic                  underrun_c;
  logic [SPI_WORD_W-1:0] reload_byte_c;
  logic [SPI_WORD_W-1:0] rx_byte_c;

  // A new tx byte is needed at frame start and on the first fall after a full byte.
  assign reload_c = ((state == IDLE) && cs_fall_c) ||
                    ((state == ACTIVE) && !cs_rise_c && sck_fall_c && (bit_cnt == '0));

  assign rx_byte_c = {rx_shift[SPI_WORD_W-2:0], mosi_level};

  // Reload source: queued byte, same-cycle bypass of tx_data, or the idle filler.
  always_comb begin
    reload_byte_c = IDLE_TX;
    underrun_c    = 1'b0;
    if (!tx_ready) begin
      reload_byte_c = hold;
    end else if (tx_load) begin
      reload_byte_c = tx_data;
    end else begin
      underrun_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= cs_level ? IDLE : WAIT_CS_HIGH;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      hold         <= '0;
      rx_pend      <= 1'b0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      tx_ready     <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_active <= 1'b0;
      frame_end    <= 1'b0;
      rx_abort     <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      rx_valid    <= rx_pend;
      rx_pend     <= 1'b0;
      frame_end   <= 1'b0;
      rx_abort    <= 1'b0;
      tx_underrun <= 1'b0;

      // Holding register and tx shift reload
      if (reload_c) begin
        tx_shift    <= reload_byte_c;
        miso        <= reload_byte_c[SPI_WORD_W-1];
        tx_underrun <= underrun_c;
        if (!tx_ready) begin
          if (tx_load) begin
            hold <= tx_data;
          end else begin
            tx_ready <= 1'b1;
          end
        end
      end else if (tx_load && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (cs_fall_c) begin
            state        <= ACTIVE;
            bit_cnt      <= '0;
            frame_active <= 1'b1;
            miso_oe      <= 1'b1;
          end
        end
        ACTIVE: begin
          // cs rise takes priority over any sck edge seen in the same cycle
          if (cs_rise_c) begin
            state        <= IDLE;
            frame_end    <= 1'b1;
            rx_abort     <= (bit_cnt != '0);
            frame_active <= 1'b0;
            miso_oe      <= 1'b0;
            miso         <= 1'b0;
            bit_cnt      <= '0;
          end else if (sck_rise_c) begin
            rx_shift <= rx_byte_c;
            bit_cnt  <= bit_cnt + SPI_CNT_W'(1);
            if (bit_cnt == SPI_CNT_W'(SPI_WORD_W - 1)) begin
              rx_data <= rx_byte_c;
              rx_pend <= 1'b1;
            end
          end else if (sck_fall_c && (bit_cnt != '0)) begin
            tx_shift <= {tx_shift[SPI_WORD_W-2:0], 1'b0};
            miso     <= tx_shift[SPI_WORD_W-2];
          end
        end
        WAIT_CS_HIGH: begin
          if (cs_level) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_spi_slave.sv
// Directed bench for tdc_spi_slave: table of single-byte frames plus
// hand-written multi-byte, abort, bypass and mid-frame reset sequences.
module tb_tdc_spi_slave;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned H           = 6;

  logic       clk = 1'b0;
  logic       rst, sck, cs, mosi, tx_load;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, frame_active, frame_end, rx_abort, tx_underrun;
  logic [7:0] rx_data;

  tdc_spi_slave #(.SYNC_STAGES(SYNC_STAGES), .IDLE_TX(8'h00)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_active(frame_active), .frame_end(frame_end),
    .rx_abort(rx_abort), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int n_valid = 0, n_fend = 0, n_abort = 0, n_abort_fend = 0, n_under = 0, n_oe = 0;
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_rx = rx_data;
    end
    if (frame_end) n_fend++;
    if (rx_abort) n_abort++;
    if (rx_abort && frame_end) n_abort_fend++;
    if (tx_underrun) n_under++;
    if (miso_oe) n_oe++;
  end

  typedef struct {
    bit         pre;
    logic [7:0] pre_v;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    int         exp_under;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_byte(input logic [7:0] v);
    int w;
    w = 0;
    while (!tx_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("load_wait_ready", 32'(tx_ready), 32'd1);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    idle(H);
  endtask

  // One byte from the master; last=1 drops sck and raises cs together.
  task automatic spi_byte(input logic [7:0] out, input bit last, input bit byp,
                          input logic [7:0] byp_val, output logic [7:0] got, output int lat);
    got = 8'h00;
    lat = 0;
    for (int b = 7; b >= 0; b--) begin
      mosi = out[b];
      idle(H);
      sck = 1'b1;
      got = {got[6:0], miso};
      for (int c = 1; c <= H; c++) begin
        @(negedge clk);
        if (b == 0 && rx_valid && lat == 0) lat = c;
      end
      sck = 1'b0;
      if (b == 0 && last) cs = 1'b1;
      if (b == 0 && byp) begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tx_data = byp_val;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
      end
    end
    if (last) idle(H);
  endtask

  task automatic run_vec(input vec_t v);
    int s_valid, s_fend, s_abort, s_under, lat;
    logic [7:0] got;
    s_valid = n_valid; s_fend = n_fend; s_abort = n_abort; s_under = n_under;
    if (v.pre) begin
      load_byte(v.pre_v);
      check("preload_full", 32'(tx_ready), 32'd0);
    end
    cs_low();
    check("active_flags", 32'({frame_active, miso_oe}), 32'd3);
    spi_byte(v.mo, 1'b1, 1'b0, 8'h00, got, lat);
    check("miso_byte", 32'(got), 32'(v.exp_miso));
    check("rx_valid_count", 32'(n_valid - s_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'(v.mo));
    check("rx_at_strobe", 32'(last_rx), 32'(v.mo));
    check("rx_latency", 32'(lat), 32'(SYNC_STAGES + 2));
    check("frame_end_count", 32'(n_fend - s_fend), 32'd1);
    check("underrun_count", 32'(n_under - s_under), 32'(v.exp_under));
    check("abort_count", 32'(n_abort - s_abort), 32'd0);
    check("tx_ready_after", 32'(tx_ready), 32'd1);
    check("idle_flags", 32'({frame_active, miso_oe}), 32'd0);
  endtask

  initial begin
    int s_valid, s_fend, s_abort, s_af, s_under, s_oe, lat;
    logic [7:0] got;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 1};
    vecs[2] = '{1'b1, 8'h0F, 8'hF0, 8'h0F, 0};
    vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 0};

    rst = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    idle(5);
    rst = 1'b0;
    idle(2);
    check("reset_flags",
          32'({miso, miso_oe, tx_ready, rx_valid, frame_active, frame_end, rx_abort, tx_underrun}),
          32'h20);
    check("reset_rx_data", 32'(rx_data), 32'h00);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Three-byte frame, refilling the holding register each time it empties
    s_valid = n_valid; s_under = n_under; s_fend = n_fend;
    load_byte(8'h11);
    cs_low();
    load_byte(8'h22);
    spi_byte(8'h01, 1'b0, 1'b0, 8'h00, got, lat);
    check("multi_miso0", 32'(got), 32'h11);
    check("multi_rx0", 32'(last_rx), 32'h01);
    load_byte(8'h33);
    spi_byte(8'h02, 1'b0, 1'b0, 8'h00, got, lat);
    check("multi_miso1", 32'(got), 32'h22);
    check("multi_rx1", 32'(last_rx), 32'h02);
    spi_byte(8'h03, 1'b1, 1'b0, 8'h00, got, lat);
    check("multi_miso2", 32'(got), 32'h33);
    check("multi_rx2", 32'(last_rx), 32'h03);
    check("multi_valid_count", 32'(n_valid - s_valid), 32'd3);
    check("multi_underrun", 32'(n_under - s_under), 32'd0);
    check("multi_frame_end", 32'(n_fend - s_fend), 32'd1);

    // Abort after five sck rises
    s_valid = n_valid; s_fend = n_fend; s_abort = n_abort; s_af = n_abort_fend;
    cs_low();
    for (int b = 0; b < 5; b++) begin
      mosi = 1'b1;
      idle(H);
      sck = 1'b1;
      idle(H);
      sck = 1'b0;
    end
    idle(H);
    cs = 1'b1;
    idle(H);
    check("abort_count", 32'(n_abort - s_abort), 32'd1);
    check("abort_with_frame_end", 32'(n_abort_fend - s_af), 32'd1);
    check("abort_frame_end", 32'(n_fend - s_fend), 32'd1);
    check("abort_no_valid", 32'(n_valid - s_valid), 32'd0);
    check("abort_rx_kept", 32'(rx_data), 32'h03);

    // Bypass: tx_load lands in the reload cycle with the register empty
    s_valid = n_valid; s_under = n_under;
    load_byte(8'hC3);
    cs_low();
    spi_byte(8'h12, 1'b0, 1'b1, 8'h5A, got, lat);
    check("bypass_miso0", 32'(got), 32'hC3);
    check("bypass_ready", 32'(tx_ready), 32'd1);
    spi_byte(8'h34, 1'b1, 1'b0, 8'h00, got, lat);
    check("bypass_miso1", 32'(got), 32'h5A);
    check("bypass_underrun", 32'(n_under - s_under), 32'd0);
    check("bypass_valid_count", 32'(n_valid - s_valid), 32'd2);
    check("bypass_rx_data", 32'(rx_data), 32'h34);
    check("bypass_ready_end", 32'(tx_ready), 32'd1);

    // Reset three bits into a frame with cs held low
    cs_low();
    for (int b = 0; b < 3; b++) begin
      mosi = 1'b1;
      idle(H);
      sck = 1'b1;
      idle(H);
      sck = 1'b0;
    end
    idle(2);
    rst = 1'b1;
    idle(1);
    s_valid = n_valid; s_fend = n_fend; s_oe = n_oe; s_under = n_under;
    idle(4);
    rst = 1'b0;
    idle(2);
    check("midrst_flags",
          32'({miso, miso_oe, tx_ready, rx_valid, frame_active, frame_end, rx_abort, tx_underrun}),
          32'h20);
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    spi_byte(8'hE7, 1'b0, 1'b0, 8'h00, got, lat);
    idle(H);
    check("midrst_no_valid", 32'(n_valid - s_valid), 32'd0);
    check("midrst_no_oe", 32'(n_oe - s_oe), 32'd0);
    check("midrst_inactive", 32'(frame_active), 32'd0);
    cs = 1'b1;
    idle(H);
    check("midrst_no_frame_end", 32'(n_fend - s_fend), 32'd0);
    check("midrst_no_underrun", 32'(n_under - s_under), 32'd0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
